// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: scans masked analog mux channels through a SPI ADC and streams samples out on AXI-stream.
module adc_scan_sequencer #(
    parameter int ADC_WIDTH     = 16,
    parameter int SETTLE_CYCLES = 250,
    parameter int SCLK_DIV      = 4,
    parameter int EOC_TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [7:0]           channel_mask,
    output logic [2:0]           mux_s,
    output logic                 adc_convst,
    input  logic                 adc_eoc,
    output logic                 adc_cs,
    output logic                 adc_sclk,
    output logic                 adc_sdi,
    input  logic                 adc_sdo,
    output logic [ADC_WIDTH-1:0] output_axis_tdata,
    output logic [2:0]           output_axis_tuser,
    output logic                 output_axis_tvalid,
    input  logic                 output_axis_tready,
    output logic                 busy,
    output logic                 timeout_error
);
    typedef enum logic [2:0] {IDLE, SETTLE, CONVST, WAIT_EOC, READ, OUTPUT} state_t;
    localparam int BW = $clog2(ADC_WIDTH + 1);

    state_t state, state_n;
    logic [31:0] cnt;
    logic [BW-1:0] bits;
    logic sclk;
    logic [2:0] ptr, base, sel, idx;
    logic go, read_done, timed_out, boundary;

    // mux_s doubles as the current channel; the search starts just past it at a channel boundary
    always_comb begin
        base = (state == IDLE) ? ptr : mux_s + 3'd1;
        sel = base;
        idx = base;
        for (int i = 7; i >= 0; i--) begin
            idx = base + 3'(i);
            if (channel_mask[idx]) sel = idx;
        end
    end

    assign go         = enable && (channel_mask != 8'd0);
    assign read_done  = (bits == BW'(ADC_WIDTH)) && !sclk;
    assign timed_out  = (state == WAIT_EOC) && !adc_eoc && (cnt == 32'(EOC_TIMEOUT - 1));
    assign boundary   = timed_out || (state == OUTPUT && output_axis_tready);

    assign adc_convst         = (state == CONVST);
    assign adc_cs             = (state != READ);
    assign adc_sclk           = sclk;
    assign adc_sdi            = 1'b0;
    assign output_axis_tuser  = mux_s;
    assign output_axis_tvalid = (state == OUTPUT);
    assign busy               = (state != IDLE);

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = go ? SETTLE : IDLE;
            SETTLE:   if (cnt == 32'(SETTLE_CYCLES - 1)) state_n = CONVST;
            CONVST:   if (cnt == 32'd1) state_n = WAIT_EOC;
            WAIT_EOC: if (adc_eoc) state_n = READ;
                      else if (timed_out) state_n = go ? SETTLE : IDLE;
            READ:     if (read_done) state_n = OUTPUT;
            OUTPUT:   if (output_axis_tready) state_n = go ? SETTLE : IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt               <= '0;
            bits              <= '0;
            sclk              <= 1'b0;
            ptr               <= 3'd0;
            mux_s             <= 3'd0;
            output_axis_tdata <= '0;
            timeout_error     <= 1'b0;
        end else begin
            if (state_n != state)
                cnt <= '0;
            else if (state == READ)
                cnt <= (cnt == 32'(SCLK_DIV - 1)) ? '0 : cnt + 32'd1;
            else
                cnt <= cnt + 32'd1;
            // mode 0: sample MSB-first on the clk edge that raises adc_sclk
            if (state == READ) begin
                if (!read_done && cnt == 32'(SCLK_DIV - 1)) begin
                    sclk <= !sclk;
                    if (!sclk) begin
                        output_axis_tdata <= {output_axis_tdata[ADC_WIDTH-2:0], adc_sdo};
                        bits              <= bits + BW'(1);
                    end
                end
            end else begin
                sclk <= 1'b0;
                bits <= '0;
            end
            if (state_n == SETTLE && state != SETTLE) mux_s <= sel;
            if (boundary) ptr <= mux_s + 3'd1;
            if (timed_out) timeout_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed vectors plus corner sequences against a behavioural SPI ADC model.
module tb_adc_scan_sequencer;
    localparam int W  = 16;
    localparam int ST = 5;
    localparam int DV = 2;
    localparam int TO = 20;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, tready = 1'b1, adc_eoc = 1'b0;
    logic [7:0] channel_mask = 8'h00, dead_mask = 8'h00;
    logic [2:0] mux_s, tuser;
    logic adc_convst, adc_cs, adc_sclk, adc_sdi, adc_sdo, tvalid, busy, timeout_error;
    logic [W-1:0] tdata;

    adc_scan_sequencer #(.ADC_WIDTH(W), .SETTLE_CYCLES(ST), .SCLK_DIV(DV), .EOC_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .channel_mask(channel_mask), .mux_s(mux_s),
        .adc_convst(adc_convst), .adc_eoc(adc_eoc), .adc_cs(adc_cs), .adc_sclk(adc_sclk),
        .adc_sdi(adc_sdi), .adc_sdo(adc_sdo), .output_axis_tdata(tdata), .output_axis_tuser(tuser),
        .output_axis_tvalid(tvalid), .output_axis_tready(tready), .busy(busy), .timeout_error(timeout_error)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word_of(input logic [2:0] ch);
        case (ch)
            3'd0:    return 16'hA5C3;
            3'd1:    return 16'h0F0F;
            3'd2:    return 16'h1234;
            3'd4:    return 16'h8001;
            3'd7:    return 16'h7E81;
            default: return {13'h0B4A, ch};
        endcase
    endfunction

    // ADC model: word loaded when CS falls, shifted out on each SCLK fall, EOC 4 cycles after CONVST
    logic [15:0] sh = 16'h0;
    int eoc_dly = 0;
    assign adc_sdo = sh[15];
    always @(negedge adc_cs) sh = word_of(mux_s);
    always @(negedge adc_sclk) if (!adc_cs) sh = {sh[14:0], 1'b0};
    always @(posedge clk) begin
        if (adc_convst) begin
            adc_eoc <= 1'b0;
            eoc_dly <= 4;
        end else if (eoc_dly == 1) begin
            adc_eoc <= !dead_mask[mux_s];
            eoc_dly <= 0;
        end else if (eoc_dly > 1) eoc_dly <= eoc_dly - 1;
    end

    // Monitor samples just before each rising edge
    logic [18:0] beats[$];
    int cyc = 0, convst_rises = 0, settle_viol = 0, stab_viol = 0, conv_len_viol = 0, inv_viol = 0, spi_viol = 0;
    int last_mux_cyc = 0, last_convst_cyc = 0, to_lat = 0, conv_len = 0, sclk_rises = 0;
    logic prev_convst = 1'b0, prev_hold = 1'b0, prev_sclk = 1'b0, prev_cs = 1'b1, to_seen = 1'b0;
    logic [2:0] prev_mux = 3'd0;
    logic [18:0] prev_beat = '0;
    always begin
        @(negedge clk);
        #3;
        cyc++;
        if (mux_s !== prev_mux) last_mux_cyc = cyc;
        if (adc_convst && !prev_convst) begin
            convst_rises++;
            if (cyc - last_mux_cyc < ST) settle_viol++;
        end
        if (adc_convst) begin
            conv_len++;
            last_convst_cyc = cyc;
        end else if (prev_convst) begin
            if (conv_len != 2) conv_len_viol++;
            conv_len = 0;
        end
        if (timeout_error && !to_seen) begin
            to_seen = 1'b1;
            to_lat = cyc - last_convst_cyc;
        end
        if ((adc_cs && adc_sclk) || (adc_convst && !adc_cs) || (adc_convst && tvalid) || adc_sdi !== 1'b0) inv_viol++;
        if (adc_sclk && !prev_sclk) sclk_rises++;
        if (adc_cs && !prev_cs) begin
            if (!rst && sclk_rises != W) spi_viol++;
            sclk_rises = 0;
        end
        if (prev_hold && {tuser, tdata} !== prev_beat) stab_viol++;
        prev_hold = tvalid && !tready;
        prev_beat = {tuser, tdata};
        if (tvalid && tready) beats.push_back({tuser, tdata});
        prev_convst = adc_convst;
        prev_mux = mux_s;
        prev_sclk = adc_sclk;
        prev_cs = adc_cs;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic wait_beats(input int n, input int limit);
        int t = 0;
        while (beats.size() < n && t < limit) begin
            @(negedge clk);
            t++;
        end
        if (beats.size() < n) bound_fail("wait_beats");
    endtask

    task automatic wait_idle(input int limit);
        int t = 0;
        while (busy && t < limit) begin
            @(negedge clk);
            t++;
        end
        if (busy) bound_fail("wait_idle");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        tready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        beats.delete();
        convst_rises = 0;
        to_seen = 1'b0;
    endtask

    function automatic logic [18:0] beat_at(input int i);
        return (beats.size() > i) ? beats[i] : 19'h7FFFF;
    endfunction

    typedef struct packed {
        logic [7:0]  mask;
        logic [18:0] e0;
        logic [18:0] e1;
        logic [18:0] e2;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int s0, c0, t;
        vecs[0] = '{8'h05, {3'd0, 16'hA5C3}, {3'd2, 16'h1234}, {3'd0, 16'hA5C3}};
        vecs[1] = '{8'h80, {3'd7, 16'h7E81}, {3'd7, 16'h7E81}, {3'd7, 16'h7E81}};
        vecs[2] = '{8'h12, {3'd1, 16'h0F0F}, {3'd4, 16'h8001}, {3'd1, 16'h0F0F}};
        vecs[3] = '{8'h94, {3'd2, 16'h1234}, {3'd4, 16'h8001}, {3'd7, 16'h7E81}};
        vecs[4] = '{8'h81, {3'd0, 16'hA5C3}, {3'd7, 16'h7E81}, {3'd0, 16'hA5C3}};

        do_reset();
        chk("reset_ctrl", {mux_s, adc_convst, adc_cs, adc_sclk, adc_sdi, tvalid, busy, timeout_error}, {3'd0, 7'b0100000});
        chk("reset_tdata", tdata, 0);
        chk("reset_tuser", tuser, 0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            channel_mask = vecs[v].mask;
            enable = 1'b1;
            wait_beats(3, 600);
            enable = 1'b0;
            wait_idle(300);
            chk($sformatf("vec%0d_beat0", v), beat_at(0), vecs[v].e0);
            chk($sformatf("vec%0d_beat1", v), beat_at(1), vecs[v].e1);
            chk($sformatf("vec%0d_beat2", v), beat_at(2), vecs[v].e2);
        end

        // empty mask: never leaves IDLE
        do_reset();
        channel_mask = 8'h00;
        enable = 1'b1;
        t = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy) t++;
        end
        chk("mask0_busy_cycles", t, 0);
        chk("mask0_convst", convst_rises, 0);

        // ch2 never signals EOC: flagged, skipped, scan continues on ch0
        do_reset();
        dead_mask = 8'h04;
        channel_mask = 8'h05;
        enable = 1'b1;
        wait_beats(2, 800);
        enable = 1'b0;
        wait_idle(300);
        dead_mask = 8'h00;
        chk("to_flag", timeout_error, 1);
        chk("to_latency", to_lat, TO + 1);
        chk("to_beat0", beat_at(0), {3'd0, 16'hA5C3});
        chk("to_beat1", beat_at(1), {3'd0, 16'hA5C3});
        repeat (20) @(negedge clk);
        chk("to_sticky", timeout_error, 1);
        do_reset();
        chk("to_cleared_by_rst", timeout_error, 0);

        // backpressure for 1000 cycles
        channel_mask = 8'h04;
        tready = 1'b0;
        enable = 1'b1;
        t = 0;
        while (!tvalid && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!tvalid) bound_fail("bp_wait_valid");
        c0 = convst_rises;
        s0 = stab_viol;
        repeat (1000) @(negedge clk);
        chk("bp_tvalid", tvalid, 1);
        chk("bp_beat", {tuser, tdata}, {3'd2, 16'h1234});
        chk("bp_no_convst", convst_rises - c0, 0);
        chk("bp_stable", stab_viol - s0, 0);
        chk("bp_no_beat", beats.size(), 0);
        tready = 1'b1;
        wait_beats(1, 10);
        chk("bp_accepted", beat_at(0), {3'd2, 16'h1234});
        enable = 1'b0;
        wait_idle(300);

        // reset in the middle of ch2 READ, then restart from ch0
        do_reset();
        channel_mask = 8'h05;
        enable = 1'b1;
        t = 0;
        while (!(mux_s == 3'd2 && !adc_cs) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (adc_cs) bound_fail("rst_wait_read");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_read_cs", adc_cs, 1);
        chk("rst_read_sclk", adc_sclk, 0);
        chk("rst_read_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        beats.delete();
        wait_beats(1, 300);
        chk("rst_restart_ch0", beat_at(0), {3'd0, 16'hA5C3});
        enable = 1'b0;
        wait_idle(300);

        // enable dropped during SETTLE of ch7: that channel still completes
        do_reset();
        channel_mask = 8'h80;
        enable = 1'b1;
        t = 0;
        while (!busy && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (!busy) bound_fail("drop_wait_busy");
        @(negedge clk);
        enable = 1'b0;
        chk("drop_mux", mux_s, 7);
        wait_idle(300);
        repeat (50) @(negedge clk);
        chk("drop_beats", beats.size(), 1);
        chk("drop_beat0", beat_at(0), {3'd7, 16'h7E81});
        chk("drop_busy", busy, 0);
        chk("drop_convst", convst_rises, 1);

        chk("settle_before_convst", settle_viol, 0);
        chk("convst_width", conv_len_viol, 0);
        chk("idle_levels", inv_viol, 0);
        chk("spi_pulse_count", spi_viol, 0);
        chk("hold_stability", stab_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 Parameter ADC_WIDTH, default 16, bits per ADC conversion result.
REQ-002 Parameter SETTLE_CYCLES, default 250, clk cycles from a mux_s change to conversion start.
REQ-003 Parameter SCLK_DIV, default 4, clk cycles per adc_sclk half-period (minimum 1).
REQ-004 Parameter EOC_TIMEOUT, default 4096, maximum clk cycles spent waiting for adc_eoc.
REQ-005 Port clk, input, 1, single clock; all logic is on the rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port enable, input, 1, run continuous scan while high.
REQ-008 Port channel_mask, input, 8, bit n set includes mux channel n in the scan.
REQ-009 Port mux_s, output, 3, analog mux select.
REQ-010 Port adc_convst, output, 1, conversion start, active high.
REQ-011 Port adc_eoc, input, 1, high when conversion complete.
REQ-012 Port adc_cs, output, 1, ADC chip select, active low.
REQ-013 Port adc_sclk, output, 1, SPI clock.
REQ-014 Port adc_sdi, output, 1, SPI data to the ADC, tied 0.
REQ-015 Port adc_sdo, input, 1, SPI data from the ADC.
REQ-016 Port output_axis_tdata, output, ADC_WIDTH, sample result.
REQ-017 Port output_axis_tuser, output, 3, channel number of the sample.
REQ-018 Port output_axis_tvalid, output, 1, AXI-stream valid.
REQ-019 Port output_axis_tready, input, 1, AXI-stream ready.
REQ-020 Port busy, output, 1, high in any state other than IDLE.
REQ-021 Port timeout_error, output, 1, sticky EOC timeout flag.

Function
REQ-022 The FSM SHALL have states IDLE, SETTLE, CONVST, WAIT_EOC, READ, OUTPUT.
REQ-023 IDLE SHALL go to SETTLE when enable=1 and channel_mask!=0, selecting the lowest set channel at or above the next-channel pointer, wrapping 7->0; mux_s SHALL update on entry to SETTLE.
REQ-024 SETTLE SHALL count SETTLE_CYCLES cycles, then go to CONVST.
REQ-025 CONVST SHALL hold adc_convst=1 for exactly 2 cycles, then go to WAIT_EOC.
REQ-026 WAIT_EOC SHALL go to READ on the first cycle with adc_eoc=1.
REQ-027 If adc_eoc is not seen within EOC_TIMEOUT cycles, WAIT_EOC SHALL set timeout_error, discard the sample, and advance to the next channel without entering OUTPUT.
REQ-028 READ SHALL drive adc_cs=0 and produce ADC_WIDTH adc_sclk pulses (SPI mode 0: idle low; adc_sdo sampled on the clk cycle adc_sclk rises; MSB first), then raise adc_cs the cycle after the last falling edge.
REQ-029 OUTPUT SHALL present tdata=sample and tuser=channel with tvalid=1; tdata and tuser SHALL hold stable until tvalid&&tready; the transfer SHALL complete on that cycle.
REQ-030 After a transfer or timeout, the FSM SHALL advance the pointer past the current channel and go to SETTLE for the next masked channel if enable=1 and channel_mask!=0, else to IDLE.
REQ-031 If only one channel is masked, it SHALL be rescanned each pass, including SETTLE.
REQ-032 channel_mask and enable changes SHALL take effect only at the channel boundary; an in-progress channel SHALL complete, including OUTPUT.
REQ-033 Backpressure SHALL stall the FSM in OUTPUT indefinitely; no sample SHALL be dropped or overwritten.
REQ-034 adc_sclk SHALL be low and adc_cs high outside READ; adc_convst SHALL be low outside CONVST.

Reset
REQ-035 On rst=1 the block SHALL return to IDLE within one cycle, including mid-READ.
REQ-036 Reset values SHALL be: mux_s=0, adc_convst=0, adc_cs=1, adc_sclk=0, adc_sdi=0, tvalid=0, tdata=0, tuser=0, busy=0, timeout_error=0, channel pointer=0.
REQ-037 timeout_error SHALL clear only on rst.

Verification
REQ-038 Scenario: mask=0x05, enable=1, ADC model returns 0xA5C3 on ch0 and 0x1234 on ch2, tready=1 -> beats (0xA5C3,0), (0x1234,2), (0xA5C3,0) in order; mux_s changes a minimum of SETTLE_CYCLES cycles before each convst.
REQ-039 Scenario: adc_eoc held 0 -> timeout_error=1 after EOC_TIMEOUT cycles, no beat for that channel, scan continues.
REQ-040 Scenario: tready=0 for 1000 cycles during OUTPUT -> tvalid stays 1, tdata/tuser stable, no further convst until accepted.
REQ-041 Scenario: rst pulsed mid-READ -> next cycle adc_cs=1, adc_sclk=0, busy=0; after release, a scan restarts at ch0.
REQ-042 Scenario: mask=0x80, then enable dropped during SETTLE -> one ch7 beat is delivered, then IDLE with busy=0.
REQ-043 Scenario: mask=0x00 with enable=1 -> busy stays 0, no convst pulses.
